// File: rtl/axi_lite_arbiter_2to1.sv
// Two-master to one-slave AXI-Lite arbiter. Read and write channels arbitrate
// independently with round-robin priority and one outstanding transaction each.
module axi_lite_arbiter_2to1 #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  // master 0 (instruction fetch)
  input  logic                s0_arvalid,
  output logic                s0_arready,
  input  logic [ADDR_W-1:0]   s0_araddr,
  output logic                s0_rvalid,
  input  logic                s0_rready,
  output logic [DATA_W-1:0]   s0_rdata,
  output logic [1:0]          s0_rresp,
  input  logic                s0_awvalid,
  output logic                s0_awready,
  input  logic [ADDR_W-1:0]   s0_awaddr,
  input  logic                s0_wvalid,
  output logic                s0_wready,
  input  logic [DATA_W-1:0]   s0_wdata,
  input  logic [DATA_W/8-1:0] s0_wstrb,
  output logic                s0_bvalid,
  input  logic                s0_bready,
  output logic [1:0]          s0_bresp,
  // master 1 (data)
  input  logic                s1_arvalid,
  output logic                s1_arready,
  input  logic [ADDR_W-1:0]   s1_araddr,
  output logic                s1_rvalid,
  input  logic                s1_rready,
  output logic [DATA_W-1:0]   s1_rdata,
  output logic [1:0]          s1_rresp,
  input  logic                s1_awvalid,
  output logic                s1_awready,
  input  logic [ADDR_W-1:0]   s1_awaddr,
  input  logic                s1_wvalid,
  output logic                s1_wready,
  input  logic [DATA_W-1:0]   s1_wdata,
  input  logic [DATA_W/8-1:0] s1_wstrb,
  output logic                s1_bvalid,
  input  logic                s1_bready,
  output logic [1:0]          s1_bresp,
  // memory slave
  output logic                m_arvalid,
  input  logic                m_arready,
  output logic [ADDR_W-1:0]   m_araddr,
  input  logic                m_rvalid,
  output logic                m_rready,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic [1:0]          m_rresp,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic                m_wvalid,
  input  logic                m_wready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic                m_bvalid,
  output logic                m_bready,
  input  logic [1:0]          m_bresp
);
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_t;

  r_state_t            r_state;
  logic                r_gnt, r_ptr, r_win, r_hs;
  logic [ADDR_W-1:0]   r_addr;
  w_state_t            w_state;
  logic                w_gnt, w_ptr, w_win, w_hs;
  logic [ADDR_W-1:0]   w_addr;
  logic                r_idle, r_data, w_idle, w_data, w_resp;

  // Everything is forced quiet while rst is high, even before the state register clears.
  assign r_idle = !rst && (r_state == R_IDLE);
  assign r_data = !rst && (r_state == R_DATA);
  assign w_idle = !rst && (w_state == W_IDLE);
  assign w_data = !rst && (w_state == W_DATA);
  assign w_resp = !rst && (w_state == W_RESP);

  // ---------------- read channel ----------------
  assign r_win      = (s0_arvalid && s1_arvalid) ? r_ptr : s1_arvalid;
  assign s0_arready = r_idle && s0_arvalid && !r_win;
  assign s1_arready = r_idle && s1_arvalid &&  r_win;
  assign r_hs       = s0_arready || s1_arready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= R_IDLE;
      r_gnt   <= 1'b0;
      r_ptr   <= 1'b0;
      r_addr  <= '0;
    end else begin
      case (r_state)
        R_IDLE: if (r_hs) begin
          r_addr  <= r_win ? s1_araddr : s0_araddr;
          r_gnt   <= r_win;
          r_ptr   <= !r_win;
          r_state <= R_ADDR;
        end
        R_ADDR:  if (m_arready) r_state <= R_DATA;
        R_DATA:  if (m_rvalid && m_rready) r_state <= R_IDLE;
        default: r_state <= R_IDLE;
      endcase
    end
  end

  assign m_arvalid = !rst && (r_state == R_ADDR);
  assign m_araddr  = r_addr;
  assign m_rready  = r_data && (r_gnt ? s1_rready : s0_rready);
  assign s0_rvalid = r_data && !r_gnt && m_rvalid;
  assign s1_rvalid = r_data &&  r_gnt && m_rvalid;
  assign s0_rdata  = m_rdata;
  assign s1_rdata  = m_rdata;
  assign s0_rresp  = m_rresp;
  assign s1_rresp  = m_rresp;

  // ---------------- write channel ----------------
  assign w_win      = (s0_awvalid && s1_awvalid) ? w_ptr : s1_awvalid;
  assign s0_awready = w_idle && s0_awvalid && !w_win;
  assign s1_awready = w_idle && s1_awvalid &&  w_win;
  assign w_hs       = s0_awready || s1_awready;

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state <= W_IDLE;
      w_gnt   <= 1'b0;
      w_ptr   <= 1'b0;
      w_addr  <= '0;
    end else begin
      case (w_state)
        W_IDLE: if (w_hs) begin
          w_addr  <= w_win ? s1_awaddr : s0_awaddr;
          w_gnt   <= w_win;
          w_ptr   <= !w_win;
          w_state <= W_ADDR;
        end
        W_ADDR:  if (m_awready) w_state <= W_DATA;
        W_DATA:  if (m_wvalid && m_wready) w_state <= W_RESP;
        W_RESP:  if (m_bvalid && m_bready) w_state <= W_IDLE;
        default: w_state <= W_IDLE;
      endcase
    end
  end

  assign m_awvalid = !rst && (w_state == W_ADDR);
  assign m_awaddr  = w_addr;
  assign m_wvalid  = w_data && (w_gnt ? s1_wvalid : s0_wvalid);
  assign m_wdata   = w_gnt ? s1_wdata : s0_wdata;
  assign m_wstrb   = w_gnt ? s1_wstrb : s0_wstrb;
  assign s0_wready = w_data && !w_gnt && m_wready;
  assign s1_wready = w_data &&  w_gnt && m_wready;
  assign m_bready  = w_resp && (w_gnt ? s1_bready : s0_bready);
  assign s0_bvalid = w_resp && !w_gnt && m_bvalid;
  assign s1_bvalid = w_resp &&  w_gnt && m_bvalid;
  assign s0_bresp  = m_bresp;
  assign s1_bresp  = m_bresp;
endmodule

// File: tb/tb_axi_lite_arbiter_2to1.sv
// Scoreboard bench for axi_lite_arbiter_2to1: two master tasks, a memory-slave model,
// and negedge monitors that pop expected grant order / responses from queues.
module tb_axi_lite_arbiter_2to1;
  localparam int AW = 32, DW = 32, SW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]    s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready;
  logic [AW-1:0] s_araddr [2];
  logic [AW-1:0] s_awaddr [2];
  logic [DW-1:0] s_wdata  [2];
  logic [SW-1:0] s_wstrb  [2];
  wire  [1:0]    s_arready, s_rvalid, s_awready, s_wready, s_bvalid;
  wire  [DW-1:0] s_rdata  [2];
  wire  [1:0]    s_rresp  [2];
  wire  [1:0]    s_bresp  [2];

  logic          m_arready, m_rvalid, m_awready, m_wready, m_bvalid;
  logic [DW-1:0] m_rdata;
  logic [1:0]    m_rresp, m_bresp;
  wire           m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready;
  wire  [AW-1:0] m_araddr, m_awaddr;
  wire  [DW-1:0] m_wdata;
  wire  [SW-1:0] m_wstrb;

  axi_lite_arbiter_2to1 #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .s0_arvalid(s_arvalid[0]), .s0_arready(s_arready[0]), .s0_araddr(s_araddr[0]),
    .s0_rvalid(s_rvalid[0]), .s0_rready(s_rready[0]), .s0_rdata(s_rdata[0]), .s0_rresp(s_rresp[0]),
    .s0_awvalid(s_awvalid[0]), .s0_awready(s_awready[0]), .s0_awaddr(s_awaddr[0]),
    .s0_wvalid(s_wvalid[0]), .s0_wready(s_wready[0]), .s0_wdata(s_wdata[0]), .s0_wstrb(s_wstrb[0]),
    .s0_bvalid(s_bvalid[0]), .s0_bready(s_bready[0]), .s0_bresp(s_bresp[0]),
    .s1_arvalid(s_arvalid[1]), .s1_arready(s_arready[1]), .s1_araddr(s_araddr[1]),
    .s1_rvalid(s_rvalid[1]), .s1_rready(s_rready[1]), .s1_rdata(s_rdata[1]), .s1_rresp(s_rresp[1]),
    .s1_awvalid(s_awvalid[1]), .s1_awready(s_awready[1]), .s1_awaddr(s_awaddr[1]),
    .s1_wvalid(s_wvalid[1]), .s1_wready(s_wready[1]), .s1_wdata(s_wdata[1]), .s1_wstrb(s_wstrb[1]),
    .s1_bvalid(s_bvalid[1]), .s1_bready(s_bready[1]), .s1_bresp(s_bresp[1]),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp)
  );

  int n_chk = 0, n_pass = 0;
  logic [AW-1:0]   ar_q[$], aw_q[$];
  logic [SW+DW-1:0] w_q[$];
  logic [33:0]     r0_q[$], r1_q[$];
  logic [1:0]      b0_q[$], b1_q[$];
  logic [1:0]      slv_bresp;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
  endtask

  function automatic logic [33:0] rd_rsp(input logic [31:0] a);
    return (a == 32'h8000_0000) ? {2'b00, 32'hDEADBEEF} : {a[3:2], a ^ 32'h5A5A_0000};
  endfunction

  // Timing: masters drive at negedge, slave at negedge+1, masters sample at +2, monitors at +3.
  task automatic rd(input int id, input logic [31:0] addr, input bit wait_r);
    int n;
    @(negedge clk);
    s_arvalid[id] = 1'b1; s_araddr[id] = addr;
    if (wait_r) begin
      if (id == 0) r0_q.push_back(rd_rsp(addr)); else r1_q.push_back(rd_rsp(addr));
    end
    n = 0; #2;
    while (!s_arready[id] && n < 200) begin @(negedge clk); #2; n++; end
    chk("ar_wait", n < 200, 1);
    chk("m_arvalid_pre", m_arvalid, 0);
    @(negedge clk);
    s_arvalid[id] = 1'b0;
    #2 chk("m_arvalid_lat1", m_arvalid, 1);
    if (wait_r) begin
      n = 0;
      while (!(s_rvalid[id] && s_rready[id]) && n < 200) begin @(negedge clk); #2; n++; end
      chk("r_wait", n < 200, 1);
      @(negedge clk);
    end
  endtask

  task automatic wr(input int id, input logic [31:0] addr, input logic [31:0] data,
                    input logic [3:0] strb, input int wdly, input int bdly, input logic [1:0] bresp);
    int n;
    @(negedge clk);
    s_bready[id] = 1'b0; s_awvalid[id] = 1'b1; s_awaddr[id] = addr;
    if (id == 0) b0_q.push_back(bresp); else b1_q.push_back(bresp);
    n = 0; #2;
    while (!s_awready[id] && n < 200) begin @(negedge clk); #2; n++; end
    chk("aw_wait", n < 200, 1);
    @(negedge clk);
    s_awvalid[id] = 1'b0;
    repeat (wdly) @(negedge clk);
    s_wvalid[id] = 1'b1; s_wdata[id] = data; s_wstrb[id] = strb;
    n = 0; #2;
    while (!s_wready[id] && n < 200) begin @(negedge clk); #2; n++; end
    chk("w_wait", n < 200, 1);
    @(negedge clk);
    s_wvalid[id] = 1'b0;
    n = 0; #2;
    while (!s_bvalid[id] && n < 200) begin @(negedge clk); #2; n++; end
    chk("b_wait", n < 200, 1);
    repeat (bdly) begin @(negedge clk); #2; chk("bvalid_hold", s_bvalid[id], 1); end
    @(negedge clk);
    s_bready[id] = 1'b1;
    @(negedge clk);
  endtask

  // memory slave: read side; a reset while data is pending abandons the beat
  initial begin
    logic [31:0] a;
    forever begin
      @(negedge clk); #1;
      if (m_arvalid && !rst) begin
        a = m_araddr;
        @(negedge clk); #1;
        m_rvalid = 1'b1; {m_rresp, m_rdata} = rd_rsp(a);
        while (!m_rready && !rst) begin @(negedge clk); #1; end
        if (rst) begin
          while (rst) begin @(negedge clk); #1; end
          repeat (2) begin @(negedge clk); #1; end
        end else begin
          @(negedge clk); #1;
        end
        m_rvalid = 1'b0;
      end
    end
  end

  // memory slave: write side
  initial begin
    forever begin
      @(negedge clk); #1;
      if (m_awvalid && !rst) begin
        @(negedge clk); #1;
        while (!m_wvalid && !rst) begin @(negedge clk); #1; end
        if (!rst) begin
          @(negedge clk); #1;
          m_bvalid = 1'b1; m_bresp = slv_bresp;
          while (!m_bready && !rst) begin @(negedge clk); #1; end
          @(negedge clk); #1;
          m_bvalid = 1'b0;
        end
      end
    end
  end

  // monitors
  always begin
    @(negedge clk); #3;
    if (!rst) begin
      if (m_arvalid && m_arready) begin
        if (ar_q.size() == 0) chk("ar_unexp", m_araddr, 0);
        else chk("m_araddr", m_araddr, ar_q.pop_front());
      end
      if (m_awvalid && m_awready) begin
        if (aw_q.size() == 0) chk("aw_unexp", m_awaddr, 0);
        else chk("m_awaddr", m_awaddr, aw_q.pop_front());
      end
      if (m_wvalid && m_wready) begin
        if (w_q.size() == 0) chk("w_unexp", {m_wstrb, m_wdata}, 0);
        else chk("m_wstrb_wdata", {m_wstrb, m_wdata}, w_q.pop_front());
      end
      if (s_rvalid[0] && s_rready[0]) begin
        if (r0_q.size() == 0) chk("s0_r_unexp", s_rvalid[0], 0);
        else chk("s0_rresp_rdata", {s_rresp[0], s_rdata[0]}, r0_q.pop_front());
      end
      if (s_rvalid[1] && s_rready[1]) begin
        if (r1_q.size() == 0) chk("s1_r_unexp", s_rvalid[1], 0);
        else chk("s1_rresp_rdata", {s_rresp[1], s_rdata[1]}, r1_q.pop_front());
      end
      if (s_bvalid[0] && s_bready[0]) begin
        if (b0_q.size() == 0) chk("s0_b_unexp", s_bvalid[0], 0);
        else chk("s0_bresp", s_bresp[0], b0_q.pop_front());
      end
      if (s_bvalid[1] && s_bready[1]) begin
        if (b1_q.size() == 0) chk("s1_b_unexp", s_bvalid[1], 0);
        else chk("s1_bresp", s_bresp[1], b1_q.pop_front());
      end
      if (s_wready[0]) chk("s0_wready_unexp", s_wready[0], 0);
    end
  end

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    s_arvalid = '0; s_awvalid = '0; s_wvalid = '0; s_rready = 2'b11; s_bready = 2'b11;
    for (int i = 0; i < 2; i++) begin
      s_araddr[i] = '0; s_awaddr[i] = '0; s_wdata[i] = '0; s_wstrb[i] = '0;
    end
    m_arready = 1'b1; m_awready = 1'b1; m_wready = 1'b1;
    m_rvalid = 1'b0; m_bvalid = 1'b0; m_rdata = '0; m_rresp = '0; m_bresp = '0;
    slv_bresp = 2'd0;

    // requests present during reset must not be accepted
    @(negedge clk);
    s_arvalid[0] = 1'b1; s_awvalid[1] = 1'b1;
    #2;
    chk("rst_s0_arready", s_arready[0], 0);
    chk("rst_s1_awready", s_awready[1], 0);
    chk("rst_m_arvalid", m_arvalid, 0);
    chk("rst_m_awvalid", m_awvalid, 0);
    chk("rst_s_rvalid", s_rvalid, 0);
    chk("rst_s_bvalid", s_bvalid, 0);
    @(negedge clk);
    s_arvalid = '0; s_awvalid = '0; rst = 1'b0;

    // single s0 read
    ar_q.push_back(32'h8000_0000);
    rd(0, 32'h8000_0000, 1);

    // simultaneous requests after reset: s0 first
    do_reset();
    ar_q.push_back(32'h100); ar_q.push_back(32'h200);
    fork
      rd(0, 32'h100, 1);
      rd(1, 32'h200, 1);
    join

    // s1 back-to-back while s0 holds arvalid: s1, s0, s1
    ar_q.push_back(32'h300); ar_q.push_back(32'h400); ar_q.push_back(32'h304);
    fork
      begin rd(1, 32'h300, 1); rd(1, 32'h304, 1); end
      begin @(negedge clk); rd(0, 32'h400, 1); end
    join

    // s1 write with delayed wvalid / bready and SLVERR response
    slv_bresp = 2'd2;
    aw_q.push_back(32'h8000_1000);
    w_q.push_back({4'h3, 32'h1234_5678});
    wr(1, 32'h8000_1000, 32'h1234_5678, 4'h3, 3, 2, 2'd2);

    // concurrent s0 read and s1 write
    slv_bresp = 2'd0;
    ar_q.push_back(32'h700);
    aw_q.push_back(32'h2000);
    w_q.push_back({4'hF, 32'hCAFE_F00D});
    fork
      rd(0, 32'h700, 1);
      wr(1, 32'h2000, 32'hCAFE_F00D, 4'hF, 0, 0, 2'd0);
    join

    // reset while R_DATA with m_rvalid high: beat is dropped
    s_rready[0] = 1'b0;
    ar_q.push_back(32'h800);
    rd(0, 32'h800, 0);
    n = 0;
    while (!m_rvalid && n < 50) begin @(negedge clk); #2; n++; end
    chk("abort_rvalid_wait", n < 50, 1);
    do_reset();
    s_rready[0] = 1'b1;
    #3;
    chk("abort_s_rvalid_a", s_rvalid, 0);
    chk("abort_m_rready_a", m_rready, 0);
    @(negedge clk); #3;
    chk("abort_s_rvalid_b", s_rvalid, 0);
    @(negedge clk);

    // tie after reset goes to s0 again
    ar_q.push_back(32'h500); ar_q.push_back(32'h600);
    fork
      rd(0, 32'h500, 1);
      rd(1, 32'h600, 1);
    join

    repeat (3) @(negedge clk);
    chk("ar_q_left", ar_q.size(), 0);
    chk("aw_q_left", aw_q.size(), 0);
    chk("w_q_left", w_q.size(), 0);
    chk("r_q_left", r0_q.size() + r1_q.size(), 0);
    chk("b_q_left", b0_q.size() + b1_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/axi_lite_arbiter_2to1.md
Name: axi_lite_arbiter_2to1

Overview:
- Two-master to one-slave AXI-Lite arbiter between the core's instruction-fetch port (s0) and data port (s1) and the single simulated memory port.
- Read and write channels are arbitrated independently, each with round-robin priority.
- Each channel allows one outstanding transaction; the grant is held until the response handshake completes.
- Downstream it drives the memory slave's AW/W/B/AR/R channels unchanged in meaning.

Parameters:
- ADDR_W, 32, address width of all AW/AR channels
- DATA_W, 32, data width of W/R channels; strobe width is DATA_W/8

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s{0,1}_arvalid  in  1  upstream read-address valid
- s{0,1}_arready  out  1  upstream read-address ready
- s{0,1}_araddr  in  ADDR_W  upstream read address
- s{0,1}_rvalid  out  1  upstream read-data valid
- s{0,1}_rready  in  1  upstream read-data ready
- s{0,1}_rdata  out  DATA_W  upstream read data
- s{0,1}_rresp  out  2  upstream read response
- s{0,1}_awvalid  in  1  upstream write-address valid
- s{0,1}_awready  out  1  upstream write-address ready
- s{0,1}_awaddr  in  ADDR_W  upstream write address
- s{0,1}_wvalid  in  1  upstream write-data valid
- s{0,1}_wready  out  1  upstream write-data ready
- s{0,1}_wdata  in  DATA_W  upstream write data
- s{0,1}_wstrb  in  DATA_W/8  upstream byte strobes
- s{0,1}_bvalid  out  1  upstream write-response valid
- s{0,1}_bready  in  1  upstream write-response ready
- s{0,1}_bresp  out  2  upstream write response
- m_arvalid, m_arready, m_araddr, m_rvalid, m_rready, m_rdata, m_rresp: downstream read channels; directions mirrored relative to s*, same widths
- m_awvalid, m_awready, m_awaddr, m_wvalid, m_wready, m_wdata, m_wstrb, m_bvalid, m_bready, m_bresp: downstream write channels; directions mirrored, same widths

Behaviour:
- Reset (rst=1 at posedge):
  - Both FSMs go to IDLE.
  - Both priority pointers select s0.
  - All valid/ready outputs are 0 during and after reset until the FSM leaves IDLE, except s*_arready/s*_awready, which follow the grant rule below from the first non-reset cycle.
  - Reset mid-transaction abandons it silently; no response is forwarded.
- Read FSM states: R_IDLE, R_ADDR, R_DATA.
- R_IDLE:
  - Winner = requester if only one s*_arvalid is high; if both are high, the master selected by the pointer.
  - s<win>_arready=1 combinationally; the loser's arready=0.
  - On handshake: latch araddr and grant id, go to R_ADDR, and set the pointer to the non-winner.
- R_ADDR:
  - m_arvalid=1 with the latched address.
  - On m_arready, go to R_DATA.
  - m_arvalid is first asserted the cycle after the upstream handshake (1-cycle latency).
- R_DATA:
  - s<grant>_rvalid=m_rvalid, rdata/rresp pass through, m_rready=s<grant>_rready.
  - The non-granted master sees rvalid=0.
  - On the m_rvalid&&m_rready handshake, return to R_IDLE; a new AR is accepted the following cycle.
- Write FSM states: W_IDLE, W_ADDR, W_DATA, W_RESP.
- W_IDLE: same arbitration on s*_awvalid with its own pointer; latch awaddr and grant, then go to W_ADDR.
- W_ADDR: m_awvalid=1 with the latched address; on m_awready, go to W_DATA.
- W_DATA:
  - m_wvalid=s<grant>_wvalid, wdata/wstrb pass through, s<grant>_wready=m_wready.
  - On handshake, go to W_RESP.
  - The non-granted master's wready=0 in every state.
- W_RESP:
  - s<grant>_bvalid=m_bvalid, bresp passes through, m_bready=s<grant>_bready.
  - On handshake, go to W_IDLE.
- Read and write channels are fully independent; simultaneous read and write from different or the same master proceed concurrently.
- The response is never returned to the non-granted master.
- A valid request held by the loser is serviced next (round-robin guarantees no starvation).
- Upstream data is not buffered: W and R pass through combinationally in their states; only the addresses and grant ids are registered.

Test Plan:
- s0 read 0x80000000 alone; slave returns rdata=0xDEADBEEF, rresp=0 -> s0_rvalid with 0xDEADBEEF; s1_rvalid stays 0; m_arvalid rises exactly 1 cycle after the s0 AR handshake.
- s0 and s1 assert arvalid in the same cycle after reset (addr 0x100/0x200) -> s0 granted first, m_araddr=0x100; after its R completes, s1 is granted with m_araddr=0x200.
- s1 issues back-to-back reads while s0 holds arvalid -> grants alternate s1, s0, s1; s0 waits at most one transaction.
- s1 writes 0x12345678, wstrb=0x3, to 0x80001000, with wvalid delayed 3 cycles and bready delayed 2 cycles -> m_wdata/m_wstrb match; s1_bvalid is held until s1_bready; bresp=2 is forwarded unchanged.
- Concurrent s0 read and s1 write -> both complete independently with no cross-routing of rvalid/bvalid.
- Assert rst during R_DATA with m_rvalid high -> no s*_rvalid after reset; the next read completes normally and s0 wins the first tie.
